// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard inputs and controller-side stall/flush outputs for hazard_stall_ctrl.
// master = pipeline (drives hazard status), slave = controller (drives enables/flushes).
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRt;
    logic [4:0]       IF_ID_RegisterRs;
    logic [4:0]       IF_ID_RegisterRt;
    logic             BranchTaken_EX_MEM;
    logic             MemAccess_EX_MEM;
    logic             MemReady;

    logic             PCWrite;
    logic             Enable_IF_ID;
    logic             Enable_ID_EX;
    logic             Enable_EX_MEM;
    logic             Enable_MEM_WB;
    logic             Flush_IF_ID;
    logic             Flush_ID_EX;
    logic             Flush_EX_MEM;
    logic             MemError;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               BranchTaken_EX_MEM, MemAccess_EX_MEM, MemReady,
        input  PCWrite, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB,
               Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, MemError, StallCycles, FlushCount
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               BranchTaken_EX_MEM, MemAccess_EX_MEM, MemReady,
        output PCWrite, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB,
               Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM, MemError, StallCycles, FlushCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: memory-wait freeze with timeout trap,
// branch flush, load-use bubble. Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;

    logic pc_write, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic fl_if_id, fl_id_ex, fl_ex_mem, mem_error;
    logic serve, load_use, mem_stall;

    assign load_use  = bus.ID_EX_MemRead && (bus.ID_EX_RegisterRt != 5'd0) &&
                       ((bus.ID_EX_RegisterRt == bus.IF_ID_RegisterRs) ||
                        (bus.ID_EX_RegisterRt == bus.IF_ID_RegisterRt));
    assign mem_stall = bus.MemAccess_EX_MEM && !bus.MemReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        serve         = 1'b0;
        mem_error     = 1'b0;
        pc_write      = 1'b0;
        en_if_id      = 1'b0;
        en_id_ex      = 1'b0;
        en_ex_mem     = 1'b0;
        en_mem_wb     = 1'b0;
        fl_if_id      = 1'b0;
        fl_id_ex      = 1'b0;
        fl_ex_mem     = 1'b0;

        if (reset) begin
            state_next    = RUN;
            wait_cnt_next = 8'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_stall) begin
                        state_next    = MEM_WAIT;
                        wait_cnt_next = 8'd1;
                    end else begin
                        serve = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Completion beats timeout when both land in the same cycle.
                    if (bus.MemReady) begin
                        serve         = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = 8'd0;
                    end else if (wait_cnt_reg >= TIMEOUT) begin
                        state_next = ERROR;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end
                ERROR: begin
                    mem_error = 1'b1;
                end
                default: begin
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end
            endcase
        end

        // A branch discards the ID instruction, so it masks any load-use match.
        if (serve) begin
            if (bus.BranchTaken_EX_MEM) begin
                pc_write  = 1'b1;
                en_if_id  = 1'b1;
                en_id_ex  = 1'b1;
                en_ex_mem = 1'b1;
                en_mem_wb = 1'b1;
                fl_if_id  = 1'b1;
                fl_id_ex  = 1'b1;
                fl_ex_mem = 1'b1;
            end else if (load_use) begin
                en_id_ex  = 1'b1;
                fl_id_ex  = 1'b1;
                en_ex_mem = 1'b1;
                en_mem_wb = 1'b1;
            end else begin
                pc_write  = 1'b1;
                en_if_id  = 1'b1;
                en_id_ex  = 1'b1;
                en_ex_mem = 1'b1;
                en_mem_wb = 1'b1;
            end
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.Enable_IF_ID  = en_if_id;
    assign bus.Enable_ID_EX  = en_id_ex;
    assign bus.Enable_EX_MEM = en_ex_mem;
    assign bus.Enable_MEM_WB = en_mem_wb;
    assign bus.Flush_IF_ID   = fl_if_id;
    assign bus.Flush_ID_EX   = fl_id_ex;
    assign bus.Flush_EX_MEM  = fl_ex_mem;
    assign bus.MemError      = mem_error;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (fl_ex_mem && (flush_cnt_reg != {CNT_W{1'b1}}))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    // Forced to zero while reset is held so every output reads zero during reset.
    assign bus.StallCycles = reset ? '0 : stall_cnt_reg;
    assign bus.FlushCount  = reset ? '0 : flush_cnt_reg;
`else
    assign bus.StallCycles = '0;
    assign bus.FlushCount  = '0;
`endif
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Drives the PC write enable plus the per-stage enable and flush controls of IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves, in priority order:

- multi-cycle data-memory waits (whole-pipeline freeze, with a timeout),
- taken branches/jumps resolved in MEM (flush younger stages),
- load-use hazards (one bubble into ID_EX).

## Interface
- MEM_TIMEOUT, 15: max consecutive MEM_WAIT cycles before the error trap; legal range 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; state returns to RUN on the next rising edge.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRt  in  5  load destination register.
- IF_ID_RegisterRs  in  5  source register of the instruction in ID.
- IF_ID_RegisterRt  in  5  source register of the instruction in ID.
- BranchTaken_EX_MEM  in  1  taken branch or jump resolved in MEM.
- MemAccess_EX_MEM  in  1  load/store occupies the MEM stage.
- MemReady  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC register load enable.
- Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB  out  1 each  pipeline register enables.
- Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM  out  1 each  synchronous clear of the register's contents to zero (bubble); only asserted together with the matching Enable.
- MemError  out  1  timeout trap active.
- StallCycles  out  CNT_W  cycles with PCWrite=0 outside reset.
- FlushCount  out  CNT_W  branch flush events.

## Operation
States are RUN, MEM_WAIT and ERROR. Outputs are combinational from the state and the inputs.

**Reset value of every output (reset=1):** PCWrite=0, all Enables=0, all Flushes=0, MemError=0, counters=0. The next state is RUN and the wait counter is cleared. Reset has priority in every state, including mid-wait and in ERROR.

**RUN**, evaluated in this priority order:
1. **Memory wait.** Condition: MemAccess_EX_MEM=1 and MemReady=0.
   - All Enables=0, PCWrite=0, Flushes=0.
   - Next state MEM_WAIT; wait counter set to 1.
2. **Branch flush.** Condition: BranchTaken_EX_MEM=1.
   - All Enables=1, PCWrite=1.
   - Flush_IF_ID=1, Flush_ID_EX=1, Flush_EX_MEM=1.
   - The load-use check is suppressed, because the ID instruction is discarded.
3. **Load-use stall.** Condition: ID_EX_MemRead=1, ID_EX_RegisterRt≠0, and ID_EX_RegisterRt equals IF_ID_RegisterRs or IF_ID_RegisterRt.
   - PCWrite=0, Enable_IF_ID=0.
   - Enable_ID_EX=1 with Flush_ID_EX=1.
   - Enable_EX_MEM=1, Enable_MEM_WB=1.
4. **Otherwise:** all Enables=1, PCWrite=1, no flush.

**MEM_WAIT**
- MemReady=0: full freeze (all Enables=0, PCWrite=0). Wait counter increments. When the counter reaches MEM_TIMEOUT, next state is ERROR.
- MemReady=1: outputs are those RUN would produce with the wait condition treated as false. A frozen branch or load-use condition is therefore served in this same cycle. Next state RUN; counter cleared.
- MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT: completion wins and the next state is RUN.

**ERROR**
- Full freeze, MemError=1.
- Exit only through reset.

Wait counter width is 8 bits.

## Timing
- Zero-cycle decision latency: a hazard seen in cycle t gates the clock edge that ends cycle t.
- Load-use costs exactly 1 bubble. In cycle t+1, ID_EX_MemRead sees the bubble (0), so the stall releases.
- Branch flush costs 3 squashed instructions and occupies 1 controller cycle.
- Memory wait of k cycles (MemReady first high on the k-th MEM_WAIT cycle): PCWrite=0 for k cycles in total, counting the entry cycle in RUN.
- MemReady=1 on the entry cycle means no wait at all; the controller stays in RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCycles increments on every cycle with reset=0 and PCWrite=0, including ERROR cycles.
  - FlushCount increments on each cycle with Flush_EX_MEM=1.
  - Both saturate at 2^CNT_W−1 and clear on reset.
- HAZARD_PERF_CNT_EN undefined:
  - StallCycles and FlushCount are constant 0.
  - No counter flops are synthesized.
  - Ports remain present.

## Test plan
- **Reset:** assert reset 2 cycles mid-MEM_WAIT → all outputs 0, MemError=0, state RUN on release; first RUN cycle with no hazard gives all Enables=1 and PCWrite=1.
- **Load-use:** ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5 → one cycle of PCWrite=0, Enable_IF_ID=0, Flush_ID_EX=1. Repeat with Rt=0 → no stall.
- **Branch vs load-use:** BranchTaken_EX_MEM=1 together with a load-use match → PCWrite=1, all three Flushes=1, no stall; FlushCount +1 (macro on).
- **Memory wait:** MemAccess_EX_MEM=1, MemReady low for 3 cycles then high → PCWrite=0 for 3 cycles, all Enables=1 on the 4th cycle, StallCycles=3.
- **Timeout:** MEM_TIMEOUT=4, MemReady held 0 → ERROR entered after the 4th MEM_WAIT cycle, MemError=1, freeze held until reset. Second run with MemReady=1 on the 4th wait cycle → returns to RUN, no error.
- **Macro off:** rerun the memory-wait scenario → StallCycles=0 and FlushCount=0 throughout.
